can_tx_scheduler: RTL and testbench

Arbitrates between the TX FIFO and TX high-priority-buffer (HPB) message slots of the CAN register bank. The HPB always wins. It fetches the winning frame's four words (ID, DLC, DW1, DW2) over the register bank's DEMUX read port using the CS/ack handshake, presents the frame to the TX bit-stream engine, and retires or retries it based on the engine's result. It sits between the register bank and the TX protocol engine.

---
 rtl/can_tx_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_can_tx_scheduler.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/can_tx_scheduler.sv
// TX message scheduler: picks the HPB or FIFO slot, reads the frame's four words from
// the register bank, hands the frame to the TX engine, then retires, retries or drops it.
module can_tx_scheduler #(
   parameter int ACK_TIMEOUT = 16,
   parameter int MAX_RETRY   = 3
) (
   input  logic        sys_clk,
   input  logic        IP2Can_reset,
   input  logic        fifo_req,
   input  logic        hpb_req,
   output logic        DEMUX2Can_CS,
   output logic [7:0]  DEMUX2Can_addr,
   input  logic [31:0] Can2DEMUX_data,
   input  logic        Can2DEMUX_ack,
   output logic        frame_valid,
   input  logic        frame_ready,
   output logic [31:0] frame_id,
   output logic [31:0] frame_dlc,
   output logic [31:0] frame_dw1,
   output logic [31:0] frame_dw2,
   output logic        frame_src,
   input  logic        tx_done,
   input  logic        tx_fail,
   output logic        fifo_done,
   output logic        hpb_done,
   output logic        frame_drop,
   output logic        timeout_err,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_GAP,
      S_PRESENT,
      S_WAIT_DONE
   } state_t;

   state_t      r_state;
   logic [1:0]  r_idx;
   logic [7:0]  r_tcnt;
   logic [7:0]  r_retry;
   logic        r_retry_pend;
   logic        r_retry_src;
   logic        r_src;
   logic        r_cs;
   logic [7:0]  r_addr;
   logic [31:0] r_id;
   logic [31:0] r_dlc;
   logic [31:0] r_dw1;
   logic [31:0] r_dw2;
   logic        r_valid;
   logic        r_fifo_done;
   logic        r_hpb_done;
   logic        r_drop;
   logic        r_terr;
   logic        r_busy;

   logic [7:0]  w_retry_nx;
   logic        w_retry_last;
   logic        w_tmo_hit;

   assign w_retry_nx   = r_retry + 8'd1;
   assign w_retry_last = (w_retry_nx == 8'(MAX_RETRY));
   assign w_tmo_hit    = (r_tcnt == 8'(ACK_TIMEOUT - 1));

   always_ff @(posedge sys_clk) begin
      if (IP2Can_reset) begin
         r_state      <= S_IDLE;
         r_idx        <= 2'd0;
         r_tcnt       <= 8'd0;
         r_retry      <= 8'd0;
         r_retry_pend <= 1'b0;
         r_retry_src  <= 1'b0;
         r_src        <= 1'b0;
         r_cs         <= 1'b0;
         r_addr       <= 8'd0;
         r_id         <= 32'd0;
         r_dlc        <= 32'd0;
         r_dw1        <= 32'd0;
         r_dw2        <= 32'd0;
         r_valid      <= 1'b0;
         r_fifo_done  <= 1'b0;
         r_hpb_done   <= 1'b0;
         r_drop       <= 1'b0;
         r_terr       <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_fifo_done <= 1'b0;
         r_hpb_done  <= 1'b0;
         r_drop      <= 1'b0;
         r_terr      <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (hpb_req || fifo_req) begin
                  r_src   <= hpb_req;
                  r_addr  <= hpb_req ? 8'h40 : 8'h30;
                  r_idx   <= 2'd0;
                  r_tcnt  <= 8'd0;
                  r_cs    <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= S_FETCH;
                  // Only a retry of the same slot keeps its failure count.
                  if (!(r_retry_pend && (r_retry_src == hpb_req))) begin
                     r_retry      <= 8'd0;
                     r_retry_pend <= 1'b0;
                  end
               end
            end
            S_FETCH: begin
               if (Can2DEMUX_ack) begin
                  case (r_idx)
                     2'd0:    r_id  <= Can2DEMUX_data;
                     2'd1:    r_dlc <= Can2DEMUX_data;
                     2'd2:    r_dw1 <= Can2DEMUX_data;
                     default: r_dw2 <= Can2DEMUX_data;
                  endcase
                  r_cs    <= 1'b0;
                  r_state <= S_GAP;
               end else if (w_tmo_hit) begin
                  r_terr  <= 1'b1;
                  r_cs    <= 1'b0;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_tcnt <= r_tcnt + 8'd1;
               end
            end
            S_GAP: begin
               if (r_idx == 2'd3) begin
                  r_valid <= 1'b1;
                  r_state <= S_PRESENT;
               end else begin
                  r_idx   <= r_idx + 2'd1;
                  r_addr  <= r_addr + 8'd4;
                  r_tcnt  <= 8'd0;
                  r_cs    <= 1'b1;
                  r_state <= S_FETCH;
               end
            end
            S_PRESENT: begin
               if (frame_ready) begin
                  r_valid <= 1'b0;
                  r_state <= S_WAIT_DONE;
               end
            end
            S_WAIT_DONE: begin
               if (tx_done) begin
                  r_hpb_done   <= r_src;
                  r_fifo_done  <= ~r_src;
                  r_retry_pend <= 1'b0;
                  r_busy       <= 1'b0;
                  r_state      <= S_IDLE;
               end else if (tx_fail) begin
                  r_retry <= w_retry_nx;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
                  if (w_retry_last) begin
                     r_drop       <= 1'b1;
                     r_hpb_done   <= r_src;
                     r_fifo_done  <= ~r_src;
                     r_retry_pend <= 1'b0;
                  end else begin
                     r_retry_pend <= 1'b1;
                     r_retry_src  <= r_src;
                  end
               end
            end
            default: begin
               r_cs    <= 1'b0;
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign DEMUX2Can_CS   = r_cs;
   assign DEMUX2Can_addr = r_addr;
   assign frame_valid    = r_valid;
   assign frame_id       = r_id;
   assign frame_dlc      = r_dlc;
   assign frame_dw1      = r_dw1;
   assign frame_dw2      = r_dw2;
   assign frame_src      = r_src;
   assign fifo_done      = r_fifo_done;
   assign hpb_done       = r_hpb_done;
   assign frame_drop     = r_drop;
   assign timeout_err    = r_terr;
   assign busy           = r_busy;

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Directed bench for can_tx_scheduler with a 2-cycle-ack register bank model.
module tb_can_tx_scheduler;

   logic        sys_clk = 1'b0;
   logic        IP2Can_reset;
   logic        fifo_req;
   logic        hpb_req;
   logic        DEMUX2Can_CS;
   logic [7:0]  DEMUX2Can_addr;
   logic [31:0] Can2DEMUX_data;
   logic        Can2DEMUX_ack;
   logic        frame_valid;
   logic        frame_ready;
   logic [31:0] frame_id;
   logic [31:0] frame_dlc;
   logic [31:0] frame_dw1;
   logic [31:0] frame_dw2;
   logic        frame_src;
   logic        tx_done;
   logic        tx_fail;
   logic        fifo_done;
   logic        hpb_done;
   logic        frame_drop;
   logic        timeout_err;
   logic        busy;

   int n_cmp = 0;
   int n_err = 0;
   logic bank_en = 1'b1;
   int   bank_cnt = 0;

   can_tx_scheduler #(.ACK_TIMEOUT(16), .MAX_RETRY(3)) dut (
      .sys_clk(sys_clk), .IP2Can_reset(IP2Can_reset),
      .fifo_req(fifo_req), .hpb_req(hpb_req),
      .DEMUX2Can_CS(DEMUX2Can_CS), .DEMUX2Can_addr(DEMUX2Can_addr),
      .Can2DEMUX_data(Can2DEMUX_data), .Can2DEMUX_ack(Can2DEMUX_ack),
      .frame_valid(frame_valid), .frame_ready(frame_ready),
      .frame_id(frame_id), .frame_dlc(frame_dlc),
      .frame_dw1(frame_dw1), .frame_dw2(frame_dw2), .frame_src(frame_src),
      .tx_done(tx_done), .tx_fail(tx_fail),
      .fifo_done(fifo_done), .hpb_done(hpb_done),
      .frame_drop(frame_drop), .timeout_err(timeout_err), .busy(busy)
   );

   always #5 sys_clk = ~sys_clk;

   function automatic logic [31:0] bank_word(input logic [7:0] a);
      case (a)
         8'h30:   return 32'h0000_0123;
         8'h34:   return 32'h0000_0008;
         8'h38:   return 32'hAABB_CCDD;
         8'h3C:   return 32'h1122_3344;
         8'h40:   return 32'h0000_07FF;
         8'h44:   return 32'h0000_0004;
         8'h48:   return 32'hCAFE_BABE;
         8'h4C:   return 32'h55AA_55AA;
         default: return 32'hDEAD_0000;
      endcase
   endfunction

   // Bank answers in the second cycle of each CS-high window.
   always @(posedge sys_clk) bank_cnt <= DEMUX2Can_CS ? bank_cnt + 1 : 0;
   assign Can2DEMUX_ack  = bank_en && DEMUX2Can_CS && (bank_cnt == 1);
   assign Can2DEMUX_data = bank_word(DEMUX2Can_addr);

   task automatic tick();
      @(negedge sys_clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic run_words(input logic [7:0] base, input int n);
      for (int k = 0; k < n; k++) begin
         chk("cs_req", {31'd0, DEMUX2Can_CS}, 32'd1);
         chk("addr", {24'd0, DEMUX2Can_addr}, 32'(base) + 32'(4 * k));
         tick();
         chk("cs_ack", {31'd0, DEMUX2Can_CS}, 32'd1);
         tick();
         chk("cs_gap", {31'd0, DEMUX2Can_CS}, 32'd0);
         tick();
      end
   endtask

   task automatic chk_frame(input logic src, input logic [31:0] id, input logic [31:0] dlc,
                            input logic [31:0] w1, input logic [31:0] w2);
      chk("valid", {31'd0, frame_valid}, 32'd1);
      chk("src", {31'd0, frame_src}, {31'd0, src});
      chk("id", frame_id, id);
      chk("dlc", frame_dlc, dlc);
      chk("dw1", frame_dw1, w1);
      chk("dw2", frame_dw2, w2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      IP2Can_reset = 1'b1;
      fifo_req = 1'b0; hpb_req = 1'b0;
      frame_ready = 1'b0; tx_done = 1'b0; tx_fail = 1'b0;
      repeat (3) tick();
      chk("rst_cs", {31'd0, DEMUX2Can_CS}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_valid", {31'd0, frame_valid}, 32'd0);
      chk("rst_id", frame_id, 32'd0);
      IP2Can_reset = 1'b0;
      tick();

      // FIFO-only frame
      fifo_req = 1'b1;
      tick();
      fifo_req = 1'b0;
      chk("t1_busy", {31'd0, busy}, 32'd1);
      run_words(8'h30, 4);
      chk_frame(1'b0, 32'h123, 32'h8, 32'hAABBCCDD, 32'h11223344);
      frame_ready = 1'b1;
      tick();
      frame_ready = 1'b0;
      chk("t1_valid_off", {31'd0, frame_valid}, 32'd0);
      chk("t1_busy_wait", {31'd0, busy}, 32'd1);
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      chk("t1_fifo_done", {31'd0, fifo_done}, 32'd1);
      chk("t1_hpb_done", {31'd0, hpb_done}, 32'd0);
      chk("t1_busy_off", {31'd0, busy}, 32'd0);
      tick();
      chk("t1_done_pulse", {31'd0, fifo_done}, 32'd0);

      // Both requests together: HPB first, then FIFO with backpressure
      fifo_req = 1'b1; hpb_req = 1'b1;
      tick();
      hpb_req = 1'b0;
      chk("t2_src_sel", {31'd0, frame_src}, 32'd1);
      run_words(8'h40, 4);
      chk_frame(1'b1, 32'h7FF, 32'h4, 32'hCAFEBABE, 32'h55AA55AA);
      frame_ready = 1'b1;
      tick();
      frame_ready = 1'b0;
      tx_done = 1'b1; tx_fail = 1'b1;
      tick();
      tx_done = 1'b0; tx_fail = 1'b0;
      chk("t2_hpb_done", {31'd0, hpb_done}, 32'd1);
      chk("t2_fifo_done", {31'd0, fifo_done}, 32'd0);
      chk("t2_no_drop", {31'd0, frame_drop}, 32'd0);
      tick();
      fifo_req = 1'b0;
      chk("t2_next_src", {31'd0, frame_src}, 32'd0);
      run_words(8'h30, 4);
      for (int c = 0; c < 5; c++) begin
         chk("bp_valid", {31'd0, frame_valid}, 32'd1);
         chk("bp_dw1", frame_dw1, 32'hAABBCCDD);
         tick();
      end
      chk_frame(1'b0, 32'h123, 32'h8, 32'hAABBCCDD, 32'h11223344);
      frame_ready = 1'b1;
      tick();
      frame_ready = 1'b0;
      chk("bp_xfer", {31'd0, frame_valid}, 32'd0);
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      chk("t2_fifo_done2", {31'd0, fifo_done}, 32'd1);
      tick();

      // Retry: three failures drop the FIFO frame
      fifo_req = 1'b1;
      tick();
      for (int r = 1; r <= 3; r++) begin
         run_words(8'h30, 4);
         chk("rt_valid", {31'd0, frame_valid}, 32'd1);
         frame_ready = 1'b1;
         tick();
         frame_ready = 1'b0;
         tx_fail = 1'b1;
         if (r == 3) fifo_req = 1'b0;
         tick();
         tx_fail = 1'b0;
         chk("rt_busy", {31'd0, busy}, 32'd0);
         chk("rt_drop", {31'd0, frame_drop}, (r == 3) ? 32'd1 : 32'd0);
         chk("rt_fifo_done", {31'd0, fifo_done}, (r == 3) ? 32'd1 : 32'd0);
         tick();
      end
      chk("rt_idle_cs", {31'd0, DEMUX2Can_CS}, 32'd0);
      chk("rt_idle_busy", {31'd0, busy}, 32'd0);

      // Ack never arrives
      bank_en = 1'b0;
      fifo_req = 1'b1;
      tick();
      fifo_req = 1'b0;
      chk("to_cs_rise", {31'd0, DEMUX2Can_CS}, 32'd1);
      for (int c = 2; c <= 16; c++) begin
         tick();
         chk("to_cs_hold", {31'd0, DEMUX2Can_CS}, 32'd1);
         chk("to_no_err", {31'd0, timeout_err}, 32'd0);
      end
      tick();
      chk("to_err", {31'd0, timeout_err}, 32'd1);
      chk("to_cs_fall", {31'd0, DEMUX2Can_CS}, 32'd0);
      chk("to_busy", {31'd0, busy}, 32'd0);
      chk("to_no_done", {31'd0, fifo_done}, 32'd0);
      tick();
      chk("to_pulse", {31'd0, timeout_err}, 32'd0);
      bank_en = 1'b1;

      // Reset during the third word fetch
      fifo_req = 1'b1;
      tick();
      run_words(8'h30, 2);
      chk("mr_addr3", {24'd0, DEMUX2Can_addr}, 32'h38);
      IP2Can_reset = 1'b1;
      tick();
      IP2Can_reset = 1'b0;
      chk("mr_cs", {31'd0, DEMUX2Can_CS}, 32'd0);
      chk("mr_addr", {24'd0, DEMUX2Can_addr}, 32'd0);
      chk("mr_busy", {31'd0, busy}, 32'd0);
      chk("mr_id", frame_id, 32'd0);
      chk("mr_valid", {31'd0, frame_valid}, 32'd0);
      tick();
      fifo_req = 1'b0;
      run_words(8'h30, 4);
      chk_frame(1'b0, 32'h123, 32'h8, 32'hAABBCCDD, 32'h11223344);
      frame_ready = 1'b1;
      tick();
      frame_ready = 1'b0;
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      chk("mr_fifo_done", {31'd0, fifo_done}, 32'd1);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
